// File: rtl/mul_pkg.sv
// Shared types and defaults for the Booth multiplier issue/capture stage.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        HOLD
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_MUL_LAT = 17;
    localparam int DEF_CNT_W   = $clog2(DEF_MUL_LAT);

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries, pointers wrap modulo DEPTH.
module mul_operand_fifo
    import mul_pkg::*;
#(
    parameter int W     = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign dout   = r_mem[r_rp];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/radix4_issue_ctrl.sv
// Issues buffered operand pairs to the Booth multiplier one job at a time
// and captures each product on a valid/ready result stream.
module radix4_issue_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_initial,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               busy
);

    localparam int CW = cnt_width(MUL_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_res;
    logic               r_ov;
    logic [2*WIDTH-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_done;

    // in_ready comes only from the registered count, never from out_ready
    assign in_ready    = !w_full && !rst;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (w_next == LOAD);
    assign w_done      = (r_state == WAIT) && (r_cnt == '0);
    assign mul_initial = (r_state == LOAD);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign out_valid   = r_ov;
    assign out_result  = r_res;
    assign busy        = (r_state != IDLE) || !w_empty;

    mul_operand_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({in_a, in_b}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next = LOAD;
                end
            end
            LOAD: w_next = WAIT;
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next = w_empty ? IDLE : LOAD;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_ov  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_a <= w_head[2*WIDTH-1:WIDTH];
                r_b <= w_head[WIDTH-1:0];
            end
            if (r_state == LOAD) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // the only cycle in which mul_result is looked at
            if (w_done) begin
                r_res <= mul_result;
                r_ov  <= 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                r_ov  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_radix4_issue_ctrl.sv
// Directed bench for radix4_issue_ctrl with a behavioural Booth multiplier
// model that only presents the true product once its latency has elapsed.
module tb_radix4_issue_ctrl;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 17;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_initial;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    int n_cmp;
    int n_bad;
    int cyc;
    int res_n;
    int ov_n;
    logic [63:0] res_mem [0:63];
    int          res_at  [0:63];

    logic signed [63:0] m_prod;
    int                 m_cnt;

    radix4_issue_ctrl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_initial (mul_initial),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        m_prod = '0;
        m_cnt  = MUL_LAT;
        cyc    = 0;
        res_n  = 0;
        ov_n   = 0;
    end

    // Latches operands while Initial is high; product is valid from the
    // MUL_LAT-th edge after Initial falls, garbage before that.
    always @(posedge clk) begin
        if (mul_initial) begin
            m_prod <= $signed(mul_a) * $signed(mul_b);
            m_cnt  <= 0;
        end else if (m_cnt < MUL_LAT) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign mul_result = (m_cnt >= MUL_LAT - 1) ? m_prod
                                               : (~m_prod ^ 64'h5a5a_c3c3_0f0f_9696);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) begin
            ov_n <= ov_n + 1;
        end
        if (out_valid && out_ready && res_n < 64) begin
            res_mem[res_n] <= out_result;
            res_at[res_n]  <= cyc;
            res_n          <= res_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input int a, input int b, output int at);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL push_timeout: in_ready got 0 want 1");
        end
        tick();
        at       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL valid_timeout: out_valid got 0 want 1");
        end
    endtask

    task automatic wait_results(input int target, input int budget);
        int n;
        n = 0;
        while (res_n < target && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (res_n < target) begin
            n_bad++;
            $display("FAIL result_timeout: results got %0d want %0d", res_n, target);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %0b want 0", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out_valid: got %0b want 0", out_valid);
        end
        n_cmp++;
        if (out_result !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_out_result: got %0h want 0", out_result);
        end
        n_cmp++;
        if (mul_initial !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mul_initial: got %0b want 0", mul_initial);
        end
        n_cmp++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_operands: got %0h/%0h want 0/0", mul_a, mul_b);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %0b want 0", busy);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_rst_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        int p;
        int n;
        out_ready = 1'b0;
        push_pair(553524, 840, p);
        n_cmp++;
        if (mul_initial !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_idle: initial/busy got %0b/%0b want 0/1", mul_initial, busy);
        end
        tick();
        n_cmp++;
        if (mul_initial !== 1'b1) begin
            n_bad++;
            $display("FAIL single_load: mul_initial got %0b want 1", mul_initial);
        end
        n_cmp++;
        if (mul_a !== 32'd553524 || mul_b !== 32'd840) begin
            n_bad++;
            $display("FAIL single_operands: got %0d/%0d want 553524/840", mul_a, mul_b);
        end
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (cyc - p !== MUL_LAT + 2) begin
            n_bad++;
            $display("FAIL single_latency: edges got %0d want %0d", cyc - p, MUL_LAT + 2);
        end
        n_cmp++;
        if (out_result !== 64'd464960160) begin
            n_bad++;
            $display("FAIL single_result: got %0d want 464960160", $signed(out_result));
        end
        n_cmp++;
        if (mul_a !== 32'd553524 || mul_b !== 32'd840) begin
            n_bad++;
            $display("FAIL single_stable_ops: got %0d/%0d want 553524/840", mul_a, mul_b);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: valid/busy got %0b/%0b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_signed_mix();
        int p;
        int b;
        b         = res_n;
        out_ready = 1'b1;
        push_pair(-259, -259, p);
        push_pair(1348760118, -1199060305, p);
        wait_results(b + 2, 150);
        out_ready = 1'b0;
        n_cmp++;
        if (res_mem[b] !== 64'd67081) begin
            n_bad++;
            $display("FAIL mix_first: got %0d want 67081", $signed(res_mem[b]));
        end
        n_cmp++;
        if ($signed(res_mem[b+1]) !== -64'sd1617244718460915990) begin
            n_bad++;
            $display("FAIL mix_second: got %0d want -1617244718460915990",
                     $signed(res_mem[b+1]));
        end
        n_cmp++;
        if (res_at[b+1] - res_at[b] !== MUL_LAT + 2) begin
            n_bad++;
            $display("FAIL mix_period: got %0d want %0d",
                     res_at[b+1] - res_at[b], MUL_LAT + 2);
        end
    endtask

    task automatic test_backpressure();
        int p;
        int b;
        longint exp [5];
        int ea [5];
        int eb [5];
        ea = '{-3, 100, 12345, -1, 65536};
        eb = '{7, -100, 6789, -1, 65536};
        exp = '{-64'sd21, -64'sd10000, 64'sd83810205, 64'sd1, 64'sd4294967296};
        b         = res_n;
        out_ready = 1'b0;
        push_pair(7, 6, p);
        wait_valid(60);
        for (int i = 0; i < 4; i++) begin
            push_pair(ea[i], eb[i], p);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full: in_ready got %0b want 0", in_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_result !== 64'd42) begin
            n_bad++;
            $display("FAIL bp_hold: ready/result got %0b/%0d want 0/42",
                     in_ready, $signed(out_result));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: ready/valid got %0b/%0b want 1/0", in_ready, out_valid);
        end
        push_pair(ea[4], eb[4], p);
        wait_valid(60);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || $signed(out_result) !== exp[0]) begin
                n_bad++;
                $display("FAIL bp_stable: valid/result got %0b/%0d want 1/%0d",
                         out_valid, $signed(out_result), exp[0]);
            end
        end
        out_ready = 1'b1;
        wait_results(b + 6, 200);
        out_ready = 1'b0;
        n_cmp++;
        if (res_mem[b] !== 64'd42) begin
            n_bad++;
            $display("FAIL bp_blocker: got %0d want 42", $signed(res_mem[b]));
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ($signed(res_mem[b+1+i]) !== exp[i]) begin
                n_bad++;
                $display("FAIL bp_drain%0d: got %0d want %0d",
                         i, $signed(res_mem[b+1+i]), exp[i]);
            end
        end
    endtask

    task automatic test_zero_identity();
        int p;
        int b;
        b         = res_n;
        out_ready = 1'b1;
        push_pair(5, 0, p);
        push_pair(1, 1348760118, p);
        push_pair(-1199060305, 1, p);
        wait_results(b + 3, 200);
        out_ready = 1'b0;
        n_cmp++;
        if (res_mem[b] !== 64'd0) begin
            n_bad++;
            $display("FAIL zero: got %0d want 0", $signed(res_mem[b]));
        end
        n_cmp++;
        if (res_mem[b+1] !== 64'd1348760118) begin
            n_bad++;
            $display("FAIL ident_b: got %0d want 1348760118", $signed(res_mem[b+1]));
        end
        n_cmp++;
        if ($signed(res_mem[b+2]) !== -64'sd1199060305) begin
            n_bad++;
            $display("FAIL ident_a: got %0d want -1199060305", $signed(res_mem[b+2]));
        end
    endtask

    task automatic test_simul_push_pop();
        int p;
        int b;
        longint exp [5];
        exp = '{-64'sd72, 64'sd100, -64'sd6,
                64'sd4611686014132420609, 64'sd4611686018427387904};
        b         = res_n;
        out_ready = 1'b0;
        push_pair(-8, 9, p);
        wait_valid(60);
        push_pair(10, 10, p);
        push_pair(-2, 3, p);
        push_pair(2147483647, 2147483647, p);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sp_three: in_ready got %0b want 1", in_ready);
        end
        in_valid  = 1'b1;
        in_a      = 32'h8000_0000;
        in_b      = 32'h8000_0000;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || mul_initial !== 1'b1) begin
            n_bad++;
            $display("FAIL sp_count: ready/initial got %0b/%0b want 1/1",
                     in_ready, mul_initial);
        end
        n_cmp++;
        if (mul_a !== 32'd10 || mul_b !== 32'd10) begin
            n_bad++;
            $display("FAIL sp_head: got %0d/%0d want 10/10", mul_a, mul_b);
        end
        wait_results(b + 5, 200);
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (res_n !== b + 5 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sp_total: results/busy got %0d/%0b want %0d/0",
                     res_n - b, busy, 5);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ($signed(res_mem[b+i]) !== exp[i]) begin
                n_bad++;
                $display("FAIL sp_order%0d: got %0d want %0d",
                         i, $signed(res_mem[b+i]), exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int p;
        int b;
        int ov0;
        int n;
        out_ready = 1'b0;
        push_pair(1000, -3, p);
        push_pair(5, 5, p);
        n = 0;
        while (!mul_initial && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_result !== 64'd0) begin
            n_bad++;
            $display("FAIL rw_out: valid/result got %0b/%0h want 0/0", out_valid, out_result);
        end
        n_cmp++;
        if (mul_initial !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_bad++;
            $display("FAIL rw_mul: init/a/b got %0b/%0h/%0h want 0/0/0",
                     mul_initial, mul_a, mul_b);
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_busy: busy/ready got %0b/%0b want 0/0", busy, in_ready);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        b         = res_n;
        tick();
        ov0 = ov_n;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_after: ready/busy got %0b/%0b want 1/0", in_ready, busy);
        end
        repeat (50) tick();
        n_cmp++;
        if (ov_n !== ov0 || res_n !== b) begin
            n_bad++;
            $display("FAIL rw_no_pulse: valid cycles got %0d want 0", ov_n - ov0);
        end
        push_pair(-77, 13, p);
        wait_results(b + 1, 60);
        out_ready = 1'b0;
        n_cmp++;
        if ($signed(res_mem[b]) !== -64'sd1001) begin
            n_bad++;
            $display("FAIL rw_new_job: got %0d want -1001", $signed(res_mem[b]));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_signed_mix();
        test_backpressure();
        test_zero_identity();
        test_simul_push_pop();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/radix4_issue_ctrl.md
# radix4_issue_ctrl

Operand-issue and result-capture stage wrapped around the Radix4 Booth multiplier. Accepts signed operand pairs through a valid/ready stream and buffers them in a small FIFO. Drives the multiplier's `Initial`/operand inputs one job at a time, waits the fixed multiply latency, captures `MulResult`, and presents it on a valid/ready result stream. Sits directly upstream and downstream of the multiplier instance; the multiplier itself is instantiated beside it, not inside it.

## Interface
- `WIDTH`, 32: operand width. The result is 2·WIDTH.
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `MUL_LAT`, 17: clk cycles from the falling edge of `Initial` until `MulResult` is valid.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept; equals !full and is 0 while `rst`.
- `in_a` in WIDTH: multiplicand, two's complement.
- `in_b` in WIDTH: multiplier, two's complement.
- `mul_initial` out 1: connects to the multiplier's `Initial`.
- `mul_a` out WIDTH: connects to `inputOne`.
- `mul_b` out WIDTH: connects to `inputTwo`.
- `mul_result` in 2·WIDTH: from `MulResult`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 2·WIDTH: signed product.
- `busy` out 1: FSM is not IDLE, or the FIFO is non-empty.

## Operation
- **FIFO push:** occurs when `in_valid && in_ready`. Pop occurs on FSM entry to LOAD. Push and pop may happen in the same cycle; the count is unchanged. When full, `in_ready`=0, so a push is impossible even if a pop occurs that cycle.
- **FSM states:** IDLE, LOAD, WAIT, HOLD.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD, one cycle:
    - `mul_initial`=1.
    - `mul_a`/`mul_b` registered from the FIFO head.
    - Next state is WAIT, with `cnt`=MUL_LAT−1.
  - WAIT: `mul_initial`=0 and `cnt` decrements each cycle. At `cnt`==0, `mul_result` is registered into `out_result`, `out_valid`←1, and the next state is HOLD.
  - HOLD: all outputs held. On `out_ready`, `out_valid`←0 and the next state is LOAD if the FIFO is non-empty, otherwise IDLE.
- **Operand stability:** `mul_a`/`mul_b` are unchanged from LOAD until the next LOAD.
- **Result sampling:** `mul_result` is sampled in exactly one cycle per job; it is ignored at all other times.
- **Arithmetic:** no arithmetic is performed in this block. `out_result` is the bit-exact 2·WIDTH signed product.
- **Reset values** (`rst` applies in any state, including mid-WAIT; the job in flight is discarded and the FIFO is emptied):
  - State = IDLE.
  - `out_valid`=0, `out_result`=0.
  - `mul_initial`=0, `mul_a`=`mul_b`=0.
  - `busy`=0, FIFO count=0.
  - `in_ready`=0 during `rst`, then 1 in the first cycle after.

## Timing
- **Issue:** a pair pushed in cycle N with the FSM idle gives IDLE at N+1, LOAD (`mul_initial` high) at N+2, and WAIT over N+3 … N+2+MUL_LAT. `out_valid` rises at N+3+MUL_LAT, so latency from push to result = MUL_LAT+3 cycles.
- **Back-to-back:** HOLD with `out_ready`=1 and a non-empty FIFO goes straight to LOAD. The job period is MUL_LAT+2 cycles when `out_ready` is held high.
- **Output handshake:** `out_valid` stays high until `out_ready` is seen. `out_result` does not change while `out_valid`=1.
- **Input handshake:** `in_ready` depends only on the registered FIFO count; there is no combinational path from `out_ready`.

## Structure
- **Package `mul_pkg`:**
  - FSM state enum {IDLE, LOAD, WAIT, HOLD}.
  - Default WIDTH/MUL_LAT constants.
  - Counter width `$clog2(MUL_LAT)`.
- **Sub-module `mul_operand_fifo`:**
  - Synchronous FIFO of DEPTH × 2·WIDTH bits.
  - Pointers wrap modulo DEPTH; count has DEPTH+1 states.
  - Ports: `clk`, `rst`, push, pop, `din`, `dout`, full, empty.
- The top holds the FSM, the counter and the output registers.

## Test plan
- **Single job:** push 553524 × 840 with the real multiplier attached → `out_result`=464960160, with `out_valid` exactly MUL_LAT+3 cycles after push.
- **Signed mix:** push (−259, −259), then (1348760118, −1199060305) back-to-back, `out_ready`=1 → results 67081 then −1617244718460915990, in order, with a job period of MUL_LAT+2.
- **Back-pressure:** push 5 pairs with `out_ready`=0.
  - `in_ready` drops after the 4th accepted push.
  - `out_result` for the first pair is held stable.
  - Releasing `out_ready` drains all 5 in order.
- **Zero/identity:** (5, 0) → 0; (1, 1348760118) → 1348760118; (−1199060305, 1) → −1199060305.
- **Simultaneous push/pop:** with the FIFO at 3 entries, push in the same cycle as entry to LOAD → count stays 3 and no entry is lost or duplicated.
- **Reset mid-WAIT:**
  - Assert `rst` for 1 cycle during WAIT → every output takes its reset value next cycle.
  - No `out_valid` pulse for the aborted job or for any queued job.
  - A new pair issued afterwards gives the correct product.
